// File: rtl/days_to_date_if.sv
// days_to_date_if -- request/response bundle for the day-number to date converter.
//   start : request strobe, sampled only while the converter is idle
//   days  : absolute day number, 1 = 0001-01-01 (proleptic Gregorian)
//   date  : {year[22:9], month[8:5], day[4:0]}, held until the next accepted start
//   busy  : conversion in flight
//   done  : one-cycle pulse when date/err are updated
//   err   : input was day 0
// master = requester side, slave = converter side.
interface days_to_date_if;
  logic        start;
  logic [21:0] days;
  logic [22:0] date;
  logic        busy;
  logic        done;
  logic        err;

  modport master (output start, days, input date, busy, done, err);
  modport slave  (input start, days, output date, busy, done, err);
endinterface

// File: rtl/days_to_date.sv
// days_to_date -- iterative day-number to calendar-date converter.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high; aborts any conversion in flight
//   bus   : days_to_date_if slave (start/days in; date/busy/done/err out)
// Strips whole 400-year cycles, then single years, then months, doing one
// subtraction (or one state change) per clock. The residue left at the end
// is the day of month. All comparisons are strict so a residue equal to the
// period length lands on the last day of that period.
module days_to_date (
  input logic          clk,
  input logic          reset,
  days_to_date_if.slave bus
);

  localparam logic [21:0] QUAD_DAYS = 22'd146097;

  typedef enum logic [1:0] {IDLE, QUAD, YEAR, MONTH} state_t;

  state_t      state, state_n;
  logic [21:0] rem, rem_n;
  logic [13:0] yr, yr_n;
  logic [3:0]  mon, mon_n;
  logic [22:0] date, date_n;
  logic        busy, busy_n;
  logic        done, done_n;
  logic        err, err_n;

  logic        leap;
  logic [21:0] ylen;
  logic [21:0] mlen;

  // Gregorian leap rule on the running year.
  assign leap = ((yr[1:0] == 2'd0) && ((yr % 14'd100) != 14'd0)) ||
                ((yr % 14'd400) == 14'd0);
  assign ylen = leap ? 22'd366 : 22'd365;

  always_comb begin
    mlen = 22'd31;
    case (mon)
      4'd2:                      mlen = leap ? 22'd29 : 22'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   mlen = 22'd30;
      default:                   mlen = 22'd31;
    endcase
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    yr_n    = yr;
    mon_n   = mon;
    date_n  = date;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = err;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.days != 22'd0) begin
            rem_n   = bus.days;
            yr_n    = 14'd1;
            mon_n   = 4'd1;
            err_n   = 1'b0;
            busy_n  = 1'b1;
            state_n = QUAD;
          end else begin
            // Day 0 has no date: flag it immediately without going busy.
            date_n = '0;
            err_n  = 1'b1;
            done_n = 1'b1;
          end
        end
      end
      QUAD: begin
        if (rem > QUAD_DAYS) begin
          rem_n = rem - QUAD_DAYS;
          yr_n  = yr + 14'd400;
        end else begin
          state_n = YEAR;
        end
      end
      YEAR: begin
        if (rem > ylen) begin
          rem_n = rem - ylen;
          yr_n  = yr + 14'd1;
        end else begin
          state_n = MONTH;
        end
      end
      MONTH: begin
        if (rem > mlen) begin
          rem_n = rem - mlen;
          mon_n = mon + 4'd1;
        end else begin
          // rem <= 31 here, so the low five bits are the day of month.
          date_n  = {yr, mon, rem[4:0]};
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rem   <= '0;
      yr    <= '0;
      mon   <= '0;
      date  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      yr    <= yr_n;
      mon   <= mon_n;
      date  <= date_n;
      busy  <= busy_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  assign bus.date = date;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.err  = err;

endmodule

// File: tb/tb_days_to_date.sv
module tb_days_to_date;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  days_to_date_if bus();

  days_to_date dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [22:0] date;
    logic        err;
    int          cyc;    // edge count at which done must be seen
    int          nbusy;  // cycles busy must have been high
    int          d;      // input day number, for the inverse check
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [22:0] pack(int y, int m, int d);
    logic [13:0] y14;
    logic [3:0]  m4;
    logic [4:0]  d5;
    y14 = y[13:0];
    m4  = m[3:0];
    d5  = d[4:0];
    return {y14, m4, d5};
  endfunction

  function automatic bit is_leap(int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int mdays(int m, int y);
    case (m)
      2:           return is_leap(y) ? 29 : 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  // Days before Jan 1 of year y.
  function automatic longint dby(int y);
    longint p;
    p = y - 1;
    return p * 365 + p / 4 - p / 100 + p / 400;
  endfunction

  // Forward encoding: date -> absolute day number.
  function automatic longint days_sum(logic [22:0] dt);
    int     y, m;
    longint s;
    y = int'(dt[22:9]);
    m = int'(dt[8:5]);
    s = dby(y);
    for (int i = 1; i < m; i++) s += mdays(i, y);
    return s + longint'(dt[4:0]);
  endfunction

  // Reference: closed-form year estimate, corrected against the forward
  // encoding, then month walk. Latency follows from the cycle/year/month counts.
  task automatic model(input int d, output logic [22:0] dt, output int n);
    int y, r, m, q;
    y = int'((longint'(d) * 400) / 146097) + 1;
    while (dby(y) >= d) y--;
    while (dby(y + 1) < d) y++;
    r = d - int'(dby(y));
    m = 1;
    while (r > mdays(m, y)) begin
      r -= mdays(m, y);
      m++;
    end
    dt = pack(y, m, r);
    q  = (d - 1) / 146097;
    n  = 4 + q + (y - 1 - 400 * q) + (m - 1);
  endtask

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d date=%0h", cyc, bus.date);
        end else begin
          e = sbq.pop_front();
          check("date",    longint'(bus.date), longint'(e.date));
          check("err",     longint'(bus.err),  longint'(e.err));
          check("latency", cyc,                e.cyc);
          check("busy_cycles", busy_cnt,       e.nbusy);
          check("busy_at_done", longint'(bus.busy), 0);
          if (!e.err) check("inverse_days_sum", days_sum(bus.date), e.d);
        end
        busy_cnt = 0;
      end
    end
  end

  // Caller must be at a negedge; start is sampled on the next rising edge.
  task automatic issue(input int d, input logic [22:0] dt, input logic e, input int n);
    bus.start = 1'b1;
    bus.days  = d[21:0];
    sbq.push_back('{date: dt, err: e, cyc: cyc + n, nbusy: e ? 0 : n - 1, d: d});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run(input int d, input logic [22:0] dt, input logic e, input int n);
    @(negedge clk);
    issue(d, dt, e, n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && sbq.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout pending=%0d expected=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic run_model(input int d);
    logic [22:0] dt;
    int          n;
    model(d, dt, n);
    run(d, dt, 1'b0, n);
    wait_idle();
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.days  = '0;
    #12;
    check("rst_date", longint'(bus.date), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_done", longint'(bus.done), 0);
    check("rst_err",  longint'(bus.err),  0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors with hand-computed dates and latencies.
    run(1,      pack(1, 1, 1),     1'b0, 4);   wait_idle();
    run(730180, pack(2000, 3, 1),  1'b0, 409); wait_idle();
    run(146097, pack(400, 12, 31), 1'b0, 414); wait_idle();
    run(693655, pack(1900, 3, 1),  1'b0, 309); wait_idle();
    run(693654, pack(1900, 2, 28), 1'b0, 308); wait_idle();
    run(365,    pack(1, 12, 31),   1'b0, 15);  wait_idle();
    run(366,    pack(2, 1, 1),     1'b0, 5);   wait_idle();
    run(0,      23'd0,             1'b1, 1);   wait_idle();
    check("err_busy_low", longint'(bus.busy), 0);
    run(1,      pack(1, 1, 1),     1'b0, 4);   wait_idle();

    // Start in the cycle done is high is accepted.
    run(366, pack(2, 1, 1), 1'b0, 5);
    for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
    issue(1, pack(1, 1, 1), 1'b0, 4);
    wait_idle();

    // Start while busy is ignored.
    run(730180, pack(2000, 3, 1), 1'b0, 409);
    repeat (20) @(negedge clk);
    bus.start = 1'b1;
    bus.days  = 22'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Reset mid-conversion: outputs clear asynchronously, no done afterwards.
    run(0, 23'd0, 1'b1, 1); wait_idle();
    run(730180, pack(2000, 3, 1), 1'b0, 409);
    repeat (98) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_date", longint'(bus.date), 0);
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_done", longint'(bus.done), 0);
    check("abort_err",  longint'(bus.err),  0);
    sbq.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (450) @(negedge clk);
    run(1, pack(1, 1, 1), 1'b0, 4); wait_idle();

    // Model-driven sweep including the top of the input range.
    run_model(4194303);
    run_model(584388);
    run_model(584389);
    for (int i = 0; i < 30; i++) run_model(int'($urandom_range(1, 4194303)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
